// File: rtl/sys_arr_pkg.sv
// Shared types and helpers for the systolic-array result drain.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package sys_arr_pkg;

    localparam int M_DEF  = 4;
    localparam int DW_DEF = 8;

    // Row/column index width; a 1x1 array still needs one index bit.
    function automatic int idx_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    typedef logic [DW_DEF-1:0] elem_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    // Flat element position of (r,c) inside a row-major tile.
    function automatic int tile_idx(input int r, input int c, input int m);
        return r * m + c;
    endfunction

endpackage

// File: rtl/sys_arr_drain_if.sv
// Tile-in / element-out handshake bundle of the result drain.
// Latency: n/a (wiring only).
// Backpressure: tile_vld/tile_rdy on the array side, out_vld/out_rdy downstream.
interface sys_arr_drain_if #(
    parameter int M  = 4,
    parameter int DW = 8
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    logic                tile_vld;
    logic                tile_rdy;
    logic [M*M*DW-1:0]   tile_data;
    logic                out_vld;
    logic                out_rdy;
    logic [DW-1:0]       out_data;
    logic [IW-1:0]       out_row;
    logic [IW-1:0]       out_col;
    logic                out_last;
    logic [15:0]         tiles_done;

    // Environment side: the array plus the downstream consumer.
    modport master (
        output tile_vld, tile_data, out_rdy,
        input  tile_rdy, out_vld, out_data, out_row, out_col, out_last, tiles_done
    );

    // Drain side.
    modport slave (
        input  tile_vld, tile_data, out_rdy,
        output tile_rdy, out_vld, out_data, out_row, out_col, out_last, tiles_done
    );
endinterface

// File: rtl/sys_arr_drain_tile_buf.sv
// Two-slot ping-pong tile store with write/read pointers and occupancy count.
// Latency: a written tile is visible on rd_tile_nxt in the same cycle it is written.
// Backpressure: rdy is registered (cnt < 2), held low through the reset cycle.
module tile_buf
    import sys_arr_pkg::*;
#(
    parameter int M  = M_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [M*M*DW-1:0]   wr_data,
    input  logic                rd_done,
    output logic [M*M*DW-1:0]   rd_tile_nxt,
    output logic [1:0]          cnt,
    output logic                rdy
);

    logic [1:0][M*M*DW-1:0] slot_q, slot_d;
    logic                   wp_q, wp_d;
    logic                   rp_q, rp_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   rdy_q, rdy_d;

    // Next slot contents, pointers and occupancy from this cycle's write/retire.
    always_comb begin
        slot_d = slot_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        if (wr_en) begin
            slot_d[wp_q] = wr_data;
            wp_d         = ~wp_q;
        end
        if (rd_done) begin
            rp_d = ~rp_q;
        end
        case ({wr_en, rd_done})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        rdy_d       = (cnt_d < 2'd2);
        // The tile the reader will be looking at after this edge.
        rd_tile_nxt = slot_d[rp_d];
    end

    // Control state; a reset empties both slots by clearing the count.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
            rdy_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
        end
    end

    // Slot payload is never read while its slot is empty, so it needs no reset.
    always_ff @(posedge CLK) begin
        slot_q <= slot_d;
    end

    assign cnt = cnt_q;
    assign rdy = rdy_q;

endmodule

// File: rtl/sys_arr_drain.sv
// Drains finished M x M tiles from the systolic array as a row-major element stream.
// Latency: element (0,0) is presented the cycle after the tile is accepted.
// Backpressure: outputs hold while out_rdy=0; tile_rdy drops when both slots are full.
module sys_arr_drain
    import sys_arr_pkg::*;
#(
    parameter int M  = M_DEF,
    parameter int DW = DW_DEF,
    parameter int IW = idx_w(M)
) (
    input  logic          CLK,
    input  logic          rst,
    sys_arr_drain_if.slave bus
);

    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);
    localparam int            TBW      = (M * M * DW > 1) ? $clog2(M * M * DW) : 1;

    drain_state_t          state_q, state_d;
    logic [IW-1:0]         row_q, row_d;
    logic [IW-1:0]         col_q, col_d;
    logic [DW-1:0]         out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [15:0]           tiles_done_q, tiles_done_d;
    logic [TBW-1:0]        elem_base;

    logic                  wr_en;
    logic                  hs;
    logic                  last_hs;
    logic [1:0]            buf_cnt;
    logic                  buf_rdy;
    logic [M*M*DW-1:0]     rd_tile_nxt;

    assign wr_en   = bus.tile_vld && buf_rdy;
    assign hs      = (state_q == STREAM) && bus.out_rdy;
    assign last_hs = hs && (row_q == LAST_IDX) && (col_q == LAST_IDX);

    tile_buf #(
        .M  (M),
        .DW (DW)
    ) u_tile_buf (
        .CLK         (CLK),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (bus.tile_data),
        .rd_done     (last_hs),
        .rd_tile_nxt (rd_tile_nxt),
        .cnt         (buf_cnt),
        .rdy         (buf_rdy)
    );

    // Read FSM with row/col walk; a finished tile chains straight into the next if one is buffered.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        tiles_done_d = tiles_done_q;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (hs) begin
                    if (col_q == LAST_IDX) begin
                        col_d = '0;
                        if (row_q == LAST_IDX) begin
                            row_d        = '0;
                            tiles_done_d = tiles_done_q + 16'd1;
                            // The other slot is occupied if it was already full or fills this edge.
                            if (!((buf_cnt == 2'd2) || wr_en)) begin
                                state_d = IDLE;
                            end
                        end else begin
                            row_d = row_q + IW'(1);
                        end
                    end else begin
                        col_d = col_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
                col_d   = '0;
            end
        endcase
    end

    // Element selected for next cycle's registered output; zero whenever not streaming.
    always_comb begin
        out_data_d = '0;
        out_last_d = 1'b0;
        elem_base  = '0;
        if (state_d == STREAM) begin
            elem_base  = TBW'(tile_idx(int'(row_d), int'(col_d), M) * DW);
            out_data_d = rd_tile_nxt[elem_base +: DW];
            out_last_d = (row_d == LAST_IDX) && (col_d == LAST_IDX);
        end
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            tiles_done_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            tiles_done_q <= tiles_done_d;
        end
    end

    assign bus.tile_rdy   = buf_rdy;
    assign bus.out_vld    = (state_q == STREAM);
    assign bus.out_data   = out_data_q;
    assign bus.out_row    = row_q;
    assign bus.out_col    = col_q;
    assign bus.out_last   = out_last_q;
    assign bus.tiles_done = tiles_done_q;

endmodule

// File: tb/tb_sys_arr_drain.sv
// Bench for sys_arr_drain: element-queue reference model, directed and random traffic.
// Latency: checks every cycle, one cycle after the inputs were applied.
// Backpressure: drives out_rdy patterns and holds tile_vld until a tile is taken.
module tb_sys_arr_drain;
    import sys_arr_pkg::*;

    localparam int TM  = 4;
    localparam int TDW = 8;
    localparam int TW  = TM * TM * TDW;

    typedef struct {
        elem_t d;
        int    r;
        int    c;
        bit    l;
    } exp_t;

    logic CLK = 1'b0;
    logic rst = 1'b0;
    always #5 CLK = ~CLK;

    sys_arr_drain_if #(.M(TM), .DW(TDW)) bus();

    sys_arr_drain #(.M(TM), .DW(TDW)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: every element still owed downstream, in order, plus tile bookkeeping.
    exp_t          q[$];
    logic [TW-1:0] pend_q[$];
    int            m_tiles  = 0;
    logic [15:0]   m_done   = 16'd0;
    bit            m_rdy    = 1'b0;
    bit            zchk     = 1'b0;
    bit            last_acc = 1'b0;
    int            hs_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] mk_tile(input int base);
        logic [TW-1:0] t;
        t = '0;
        for (int i = 0; i < TM * TM; i++) t[i*TDW +: TDW] = 8'(base + i);
        return t;
    endfunction

    function automatic logic [TW-1:0] rnd_tile();
        logic [TW-1:0] t;
        for (int i = 0; i < TW / 32; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    task automatic push_tile(input logic [TW-1:0] t);
        exp_t e;
        for (int r = 0; r < TM; r++) begin
            for (int c = 0; c < TM; c++) begin
                e.d = t[tile_idx(r, c, TM)*TDW +: TDW];
                e.r = r;
                e.c = c;
                e.l = (r == TM - 1) && (c == TM - 1);
                q.push_back(e);
            end
        end
    endtask

    // Advance the model over the coming edge, take the edge, then compare.
    task automatic step();
        bit   acc;
        bit   hs;
        exp_t e;
        if (!rst) begin
            q.delete();
            m_tiles  = 0;
            m_done   = 16'd0;
            m_rdy    = 1'b0;
            zchk     = 1'b1;
            last_acc = 1'b0;
        end else begin
            acc = bus.tile_vld && m_rdy;
            hs  = (q.size() != 0) && bus.out_rdy;
            if (hs) begin
                e = q.pop_front();
                hs_cnt++;
                if (e.l) begin
                    m_tiles--;
                    m_done++;
                end
            end
            if (acc) begin
                push_tile(bus.tile_data);
                m_tiles++;
            end
            m_rdy    = (m_tiles < 2);
            zchk     = 1'b0;
            last_acc = acc;
        end
        @(posedge CLK);
        @(negedge CLK);
        chk("tile_rdy", 32'(bus.tile_rdy), 32'(m_rdy));
        chk("out_vld", 32'(bus.out_vld), 32'(q.size() != 0));
        chk("tiles_done", 32'(bus.tiles_done), 32'(m_done));
        if (q.size() != 0) begin
            chk("out_data", 32'(bus.out_data), 32'(q[0].d));
            chk("out_row", 32'(bus.out_row), 32'(q[0].r));
            chk("out_col", 32'(bus.out_col), 32'(q[0].c));
            chk("out_last", 32'(bus.out_last), 32'(q[0].l));
        end else if (zchk) begin
            chk("rst_data", 32'(bus.out_data), 32'd0);
            chk("rst_row", 32'(bus.out_row), 32'd0);
            chk("rst_col", 32'(bus.out_col), 32'd0);
            chk("rst_last", 32'(bus.out_last), 32'd0);
        end
    endtask

    // One cycle: offer the head pending tile (garbage data when none), set out_rdy.
    task automatic cyc(input bit rdy);
        bus.out_rdy = rdy;
        if (pend_q.size() != 0) begin
            bus.tile_vld  = 1'b1;
            bus.tile_data = pend_q[0];
        end else begin
            bus.tile_vld  = 1'b0;
            bus.tile_data = rnd_tile();
        end
        step();
        if (last_acc) void'(pend_q.pop_front());
    endtask

    task automatic drain_all(input int budget);
        int n;
        n = 0;
        while ((q.size() != 0 || pend_q.size() != 0) && n < budget) begin
            cyc(1'b1);
            n++;
        end
        chk("drain_budget", 32'(q.size() + pend_q.size()), 32'd0);
        cyc(1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pend_q.delete();
        cyc(1'b1);
        cyc(1'b1);
        rst = 1'b1;
        cyc(1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int start;
        bus.tile_vld  = 1'b0;
        bus.tile_data = '0;
        bus.out_rdy   = 1'b0;

        // Reset state, then a single ordered tile at full rate.
        do_reset();
        pend_q.push_back(mk_tile(0));
        repeat (20) cyc(1'b1);
        drain_all(50);

        // Same tile under alternating backpressure.
        pend_q.push_back(mk_tile(0));
        for (int i = 0; i < 40; i++) cyc(i % 2 == 0);
        drain_all(50);

        // Three tiles against a stalled consumer, then an unbroken 48-element drain.
        pend_q.push_back(mk_tile(8'h00));
        pend_q.push_back(mk_tile(8'h40));
        pend_q.push_back(mk_tile(8'h80));
        repeat (40) cyc(1'b0);
        drain_all(100);

        // New tile accepted on the very edge the last element of the current one retires.
        pend_q.push_back(mk_tile(8'h10));
        n = 0;
        while (q.size() != 1 && n < 50) begin
            cyc(1'b1);
            n++;
        end
        chk("coinc_reach", 32'(q.size()), 32'd1);
        pend_q.push_back(mk_tile(8'h20));
        cyc(1'b1);
        drain_all(50);

        // Reset after seven handshakes with a second tile buffered.
        pend_q.push_back(mk_tile(8'h30));
        pend_q.push_back(mk_tile(8'h60));
        start = hs_cnt;
        n = 0;
        while (hs_cnt - start < 7 && n < 50) begin
            cyc(1'b1);
            n++;
        end
        chk("pre_rst_hs", 32'(hs_cnt - start), 32'd7);
        rst = 1'b0;
        pend_q.delete();
        cyc(1'b1);
        rst = 1'b1;
        repeat (5) cyc(1'b1);
        pend_q.push_back(mk_tile(8'h55));
        drain_all(50);

        // Counter wrap: preload near the top, then drain two tiles.
        force dut.tiles_done_q = 16'hFFFE;
        m_done = 16'hFFFE;
        cyc(1'b0);
        release dut.tiles_done_q;
        pend_q.push_back(rnd_tile());
        pend_q.push_back(rnd_tile());
        drain_all(100);

        // Random tiles, random backpressure, occasional reset.
        for (int i = 0; i < 600; i++) begin
            if (pend_q.size() == 0 && $urandom_range(0, 2) == 0) pend_q.push_back(rnd_tile());
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                pend_q.delete();
                cyc(1'b1);
                rst = 1'b1;
            end
            cyc($urandom_range(0, 3) != 0);
        end
        drain_all(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
